universal_shift_register: RTL and testbench

- Parametrised WIDTH-bit register with an enable, eight operating modes, serial in/out at both ends, and true/complement outputs.
- Successor to the single-bit level-sensitive storage element: now edge-triggered, multi-bit, with load, shift, rotate, arithmetic-shift and clear operations.
- Serves as the general-purpose storage/shift primitive for lab datapaths: serial links, LFSR seeding, accumulators.

---
 rtl/usr_pkg.sv | 15 +
 rtl/usr_next_value.sv | 48 ++++
 rtl/universal_shift_register.sv | 73 +++++++
 tb/tb_universal_shift_register.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Mode encodings and type shared by the universal shift register and its next-state mux.
package usr_pkg;

    typedef logic [2:0] usr_mode_t;

    localparam usr_mode_t MODE_HOLD = 3'b000;
    localparam usr_mode_t MODE_LOAD = 3'b001;
    localparam usr_mode_t MODE_SHL  = 3'b010;
    localparam usr_mode_t MODE_SHR  = 3'b011;
    localparam usr_mode_t MODE_ROL  = 3'b100;
    localparam usr_mode_t MODE_ROR  = 3'b101;
    localparam usr_mode_t MODE_ASR  = 3'b110;
    localparam usr_mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_next_value.sv
// Next-state mux for the universal shift register: purely combinational, zero latency.
// No backpressure; carry ports exist only when USR_STATUS_FLAGS_EN is defined.
module usr_next_value
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  usr_mode_t        mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
`ifdef USR_STATUS_FLAGS_EN
    input  logic             carry,
    output logic             next_carry,
`endif
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
`ifdef USR_STATUS_FLAGS_EN
        next_carry = carry;
`endif
        case (mode)
            MODE_HOLD: next_q = q;
            MODE_LOAD: next_q = d;
            MODE_SHL:  next_q = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  next_q = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  next_q = '0;
            default:   next_q = q;
        endcase
`ifdef USR_STATUS_FLAGS_EN
        // Carry is the bit leaving the register; rotates report the wrapped bit.
        case (mode)
            MODE_LOAD, MODE_CLR: next_carry = 1'b0;
            MODE_SHL, MODE_ROL:  next_carry = q[WIDTH-1];
            MODE_SHR, MODE_ROR,
            MODE_ASR:            next_carry = q[0];
            default:             next_carry = carry;
        endcase
`endif
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit load/shift/rotate/clear register with serial I/O; USR_STATUS_FLAGS_EN adds Zero/Carry.
// Latency: one Clk edge per operation. No backpressure: En=0 simply holds the contents.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             SerOutL,
    output logic             SerOutR
`ifdef USR_STATUS_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Carry
`endif
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_nxt;
`ifdef USR_STATUS_FLAGS_EN
    logic             carry_reg;
    logic             carry_nxt;
`endif

    usr_next_value #(.WIDTH(WIDTH)) u_next (
        .q          (q_reg),
        .mode       (usr_mode_t'(Mode)),
        .d          (D),
        .ser_in_l   (SerInL),
        .ser_in_r   (SerInR),
`ifdef USR_STATUS_FLAGS_EN
        .carry      (carry_reg),
        .next_carry (carry_nxt),
`endif
        .next_q     (q_nxt)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q_reg <= RESET_VAL;
        end else if (En) begin
            q_reg <= q_nxt;
        end
    end

`ifdef USR_STATUS_FLAGS_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            carry_reg <= 1'b0;
        end else if (En) begin
            carry_reg <= carry_nxt;
        end
    end

    assign Carry = carry_reg;
    assign Zero  = (q_reg == '0);
`endif

    assign Q       = q_reg;
    assign notQ    = ~q_reg;
    assign SerOutL = q_reg[WIDTH-1];
    assign SerOutR = q_reg[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed plus randomized bench for universal_shift_register (WIDTH=8, RESET_VAL=8'hA5).
module tb_universal_shift_register;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       En = 1'b0;
    logic [2:0] Mode = 3'b000;
    logic [7:0] D = 8'h00;
    logic       SerInL = 1'b0;
    logic       SerInR = 1'b0;
    logic [7:0] Q;
    logic [7:0] notQ;
    logic       SerOutL;
    logic       SerOutR;
`ifdef USR_STATUS_FLAGS_EN
    logic       Zero;
    logic       Carry;
    logic       mc;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] mq;

    universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .En      (En),
        .Mode    (Mode),
        .D       (D),
        .SerInL  (SerInL),
        .SerInR  (SerInR),
        .Q       (Q),
        .notQ    (notQ),
        .SerOutL (SerOutL),
        .SerOutR (SerOutR)
`ifdef USR_STATUS_FLAGS_EN
        ,
        .Zero    (Zero),
        .Carry   (Carry)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, 64'(Q), 64'(mq));
        check({tag, ".notq"}, 64'(notQ), 64'(8'hFF - mq));
        check({tag, ".ser"}, {62'd0, SerOutL, SerOutR}, 64'((mq / 128) * 2 + (mq % 2)));
`ifdef USR_STATUS_FLAGS_EN
        check({tag, ".zero"}, 64'(Zero), 64'(mq == 0));
        check({tag, ".carry"}, 64'(Carry), 64'(mc));
`endif
    endtask

    // Reference behaviour written as plain arithmetic on the register value.
    task automatic model(input logic [2:0] m, input logic [7:0] dd, input logic sl, input logic sr);
        int v;
        int out_bit;
        v = int'(mq);
        out_bit = -1;
        case (m)
            3'd1: begin v = int'(dd); out_bit = 0; end
            3'd2: begin out_bit = v / 128; v = (v * 2) % 256 + int'(sr); end
            3'd3: begin out_bit = v % 2; v = v / 2 + 128 * int'(sl); end
            3'd4: begin out_bit = v / 128; v = (v * 2) % 256 + v / 128; end
            3'd5: begin out_bit = v % 2; v = v / 2 + 128 * (v % 2); end
            3'd6: begin out_bit = v % 2; v = v / 2 + (v >= 128 ? 128 : 0); end
            3'd7: begin v = 0; out_bit = 0; end
            default: ;
        endcase
        mq = 8'(v);
`ifdef USR_STATUS_FLAGS_EN
        if (out_bit >= 0) mc = (out_bit != 0);
`else
        if (out_bit > 1) $display("model carry out of range");
`endif
    endtask

    // Called away from the rising edge; returns #1 after the edge that applied the operation.
    task automatic step(input string tag, input logic [2:0] m, input logic e,
                        input logic [7:0] dd, input logic sl, input logic sr);
        Mode = m; En = e; D = dd; SerInL = sl; SerInR = sr;
        @(posedge Clk); #1;
        if (e) model(m, dd, sl, sr);
        check_all(tag);
    endtask

    // Async reset pulse between edges, held across one edge with a LOAD pending to prove priority.
    task automatic reset_pulse(input string tag);
        #2;
        Reset_n = 1'b0;
        #1;
        mq = 8'hA5;
`ifdef USR_STATUS_FLAGS_EN
        mc = 1'b0;
`endif
        check_all({tag, ".async"});
        check({tag, ".async_lit"}, 64'(Q), 64'h00A5);
        Mode = 3'd1; En = 1'b1; D = 8'h3C;
        @(posedge Clk); #1;
        check_all({tag, ".held"});
        Reset_n = 1'b1;
    endtask

    initial begin
        mq = 8'h00;
`ifdef USR_STATUS_FLAGS_EN
        mc = 1'b0;
`endif
        // Reset and enable gating.
        reset_pulse("rst");
        check("rst.notq_lit", 64'(notQ), 64'h005A);
        for (int i = 0; i < 3; i++) step("rst.en0", 3'd2, 1'b0, 8'h00, 1'b1, 1'b1);
        check("rst.stay", 64'(Q), 64'h00A5);

        // Load and shift.
        step("ld81", 3'd1, 1'b1, 8'h81, 1'b0, 1'b0);
        step("shl",  3'd2, 1'b1, 8'h00, 1'b0, 1'b1);
        check("shl.lit", 64'(Q), 64'h0003);
        step("shr",  3'd3, 1'b1, 8'h00, 1'b0, 1'b0);
        check("shr.lit", 64'(Q), 64'h0001);
        check("shr.serr", 64'(SerOutR), 64'd1);

        // Rotate and arithmetic shift.
        step("ld96", 3'd1, 1'b1, 8'h96, 1'b0, 1'b0);
        step("rol",  3'd4, 1'b1, 8'h00, 1'b0, 1'b0);
        check("rol.lit", 64'(Q), 64'h002D);
        step("ror",  3'd5, 1'b1, 8'h00, 1'b0, 1'b0);
        check("ror.lit", 64'(Q), 64'h0096);
        step("asr1", 3'd6, 1'b1, 8'h00, 1'b0, 1'b0);
        check("asr1.lit", 64'(Q), 64'h00CB);
        step("asr2", 3'd6, 1'b1, 8'h00, 1'b0, 1'b0);
        check("asr2.lit", 64'(Q), 64'h00E5);

        // Enable gating and clear.
        step("ldff", 3'd1, 1'b1, 8'hFF, 1'b0, 1'b0);
        step("clr_en0a", 3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        step("clr_en0b", 3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        check("clr_en0.lit", 64'(Q), 64'h00FF);
        step("clr", 3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
        check("clr.lit", 64'(Q), 64'h0000);

        // Mid-operation reset, then shifting resumes from the reset value.
        step("ld01", 3'd1, 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("shl_run", 3'd2, 1'b1, 8'h00, 1'b0, 1'b0);
        check("shl_run.lit", 64'(Q), 64'h0008);
        reset_pulse("midrst");
        step("resume", 3'd2, 1'b1, 8'h00, 1'b0, 1'b0);
        check("resume.lit", 64'(Q), 64'h004A);

`ifdef USR_STATUS_FLAGS_EN
        step("fl_ld80", 3'd1, 1'b1, 8'h80, 1'b0, 1'b0);
        step("fl_shl",  3'd2, 1'b1, 8'h00, 1'b0, 1'b0);
        check("fl_shl.carry", 64'(Carry), 64'd1);
        check("fl_shl.zero", 64'(Zero), 64'd1);
        step("fl_ld01", 3'd1, 1'b1, 8'h01, 1'b0, 1'b0);
        check("fl_ld01.carry", 64'(Carry), 64'd0);
`endif

        // Randomized operations with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] m;
            logic       e;
            logic [7:0] dd;
            logic       sl;
            logic       sr;
            m  = 3'($urandom_range(0, 7));
            e  = ($urandom_range(0, 3) != 0);
            dd = 8'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            if ($urandom_range(0, 49) == 0) reset_pulse("rnd_rst");
            else step("rnd", m, e, dd, sl, sr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
